dmem_arbiter: RTL and testbench

- Shares the single 512-byte data memory between the CPU MEM stage and a debug/loader port (program load, memory inspection).
- Each cycle it grants one port, drives the memory's read/write, byte-enable, address and write-data inputs, and returns read data.
- The CPU has priority. A starvation counter guarantees the debug port a grant within a bounded number of cycles, stalling the CPU when needed.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/arb_starve_cnt.sv | 33 +++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================
// dmem_pkg : shared types and constants for the data-memory arbiter
// Revision : 1.0
// ============================================================
package dmem_pkg;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int DMEM_BYTES = 512;

    typedef struct packed {
        logic        we;
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================
// arb_starve_cnt : saturating denied-cycle counter for the debug port
// Revision       : 1.0
// ============================================================
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);
    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_grant = (r_cnt == LIMIT);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================
// dmem_arbiter : CPU / debug-port arbiter for the shared data memory
// Revision     : 1.0
// ============================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_byte_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_valid,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_byte_en,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    logic     w_force;
    logic     w_grant_dbg;
    logic     w_grant_cpu;
    logic     w_dbg_rd_hs;
    mem_req_t w_cpu_req;
    mem_req_t w_dbg_req;
    mem_req_t w_sel;
    logic     r_dbg_rvalid;
    logic [31:0] r_dbg_rdata;

    assign w_cpu_req = '{we: cpu_we, byte_en: cpu_byte_en, addr: cpu_addr, wdata: cpu_wdata};
    assign w_dbg_req = '{we: dbg_we, byte_en: dbg_byte_en, addr: dbg_addr, wdata: dbg_wdata};

    // CPU has priority unless the debug port has waited STARVE_LIMIT cycles
    assign w_grant_dbg = ~rst & dbg_valid & (w_force | ~cpu_req);
    assign w_grant_cpu = ~rst & cpu_req & ~w_grant_dbg;
    assign w_dbg_rd_hs = w_grant_dbg & ~dbg_we;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (dbg_valid & ~w_grant_dbg),
        .clr         (w_grant_dbg | ~dbg_valid),
        .force_grant (w_force)
    );

    always_comb begin
        w_sel = '{we: 1'b0, byte_en: BE_WORD, addr: 32'd0, wdata: 32'd0};
        if (w_grant_dbg) begin
            w_sel = w_dbg_req;
        end else if (w_grant_cpu) begin
            w_sel = w_cpu_req;
        end
    end

    assign mem_read    = (w_grant_dbg | w_grant_cpu) & ~w_sel.we;
    assign mem_write   = (w_grant_dbg | w_grant_cpu) &  w_sel.we;
    assign mem_byte_en = w_sel.byte_en;
    assign mem_addr    = w_sel.addr;
    assign mem_wdata   = w_sel.wdata;

    assign cpu_stall = cpu_req & ~w_grant_cpu & ~rst;
    assign cpu_rdata = (w_grant_cpu & ~cpu_we) ? mem_rdata : 32'd0;
    assign dbg_ready = w_grant_dbg;

    // dbg_rdata only changes on a debug read; writes leave it untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= 32'd0;
        end else begin
            r_dbg_rvalid <= w_dbg_rd_hs;
            if (w_dbg_rd_hs) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================
// tb_dmem_arbiter : directed self-checking bench with a byte-array memory model
// Revision        : 1.0
// ============================================================
module tb_dmem_arbiter;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0]  cpu_byte_en = 4'hF;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid = 1'b0, dbg_we = 1'b0;
    logic [3:0]  dbg_byte_en = 4'hF;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte_en(cpu_byte_en),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_byte_en(dbg_byte_en),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: lane-masked writes, reads sign-extended by byte_en
    logic [7:0] mem [512];
    initial for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) mem[(mem_addr[8:0] + 9'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    logic [31:0] w_word;
    always_comb begin
        w_word    = {mem[mem_addr[8:0] + 9'd3], mem[mem_addr[8:0] + 9'd2],
                     mem[mem_addr[8:0] + 9'd1], mem[mem_addr[8:0]]};
        mem_rdata = w_word;
        case (mem_byte_en)
            4'b0001: mem_rdata = {{24{w_word[7]}},  w_word[7:0]};
            4'b0011: mem_rdata = {{16{w_word[15]}}, w_word[15:0]};
            default: mem_rdata = w_word;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_byte_en = be; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dbg(input logic v, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
        dbg_valid = v; dbg_we = we; dbg_byte_en = be; dbg_addr = addr; dbg_wdata = wd;
    endtask

    int n;

    initial begin
        // Reset with both requesters active
        rst = 1'b1;
        set_cpu(1, 1, 4'hF, 32'h10, 32'h11111111);
        set_dbg(1, 1, 4'hF, 32'h14, 32'h22222222);
        tick(); #2;
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_read",  32'(mem_read), 0);
        chk("rst_dbg_ready", 32'(dbg_ready), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        set_cpu(0, 0, 4'hF, 0, 0);
        set_dbg(0, 0, 4'hF, 0, 0);
        tick();
        rst = 1'b0;

        // CPU alone: SW then LW
        set_cpu(1, 1, 4'hF, 32'h10, 32'hDEADBEEF); #2;
        chk("cpu_sw_write", 32'(mem_write), 1);
        chk("cpu_sw_addr", mem_addr, 32'h10);
        chk("cpu_sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("cpu_sw_stall", 32'(cpu_stall), 0);
        tick();
        set_cpu(1, 0, 4'hF, 32'h10, 0); #2;
        chk("cpu_lw_read", 32'(mem_read), 1);
        chk("cpu_lw_write", 32'(mem_write), 0);
        chk("cpu_lw_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_lw_stall", 32'(cpu_stall), 0);
        tick();
        set_cpu(0, 0, 4'hF, 0, 0); #2;
        chk("idle_read", 32'(mem_read), 0);
        chk("idle_be", 32'(mem_byte_en), 32'hF);
        chk("idle_cpu_rdata", cpu_rdata, 0);

        // Debug alone: SB 0x80 at 0x20, then byte read
        tick();
        set_dbg(1, 1, 4'b0001, 32'h20, 32'h00000080); #2;
        chk("dbg_sb_ready", 32'(dbg_ready), 1);
        chk("dbg_sb_write", 32'(mem_write), 1);
        chk("dbg_sb_be", 32'(mem_byte_en), 32'h1);
        tick();
        set_dbg(1, 0, 4'b0001, 32'h20, 0); #2;
        chk("dbg_sb_no_rvalid", 32'(dbg_rvalid), 0);
        chk("dbg_lb_ready", 32'(dbg_ready), 1);
        chk("dbg_lb_read", 32'(mem_read), 1);
        tick();
        set_dbg(0, 0, 4'hF, 0, 0); #2;
        chk("dbg_lb_rvalid", 32'(dbg_rvalid), 1);
        chk("dbg_lb_rdata", dbg_rdata, 32'hFFFFFF80);
        tick(); #2;
        chk("dbg_rvalid_pulse", 32'(dbg_rvalid), 0);
        chk("dbg_rdata_hold", dbg_rdata, 32'hFFFFFF80);

        // Starvation: CPU held, debug forced through on the 9th cycle
        set_cpu(1, 0, 4'hF, 32'h10, 0);
        set_dbg(1, 0, 4'hF, 32'h10, 0);
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            #2;
            chk($sformatf("starve_denied_%0d", i), 32'(dbg_ready), 0);
            chk($sformatf("starve_nostall_%0d", i), 32'(cpu_stall), 0);
            tick();
        end
        #2;
        chk("starve_forced_ready", 32'(dbg_ready), 1);
        chk("starve_forced_stall", 32'(cpu_stall), 1);
        chk("starve_forced_cpu_rdata", cpu_rdata, 0);
        tick();
        set_dbg(0, 0, 4'hF, 0, 0); #2;
        chk("starve_cpu_back", 32'(cpu_stall), 0);
        chk("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("starve_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("starve_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
        tick();

        // Early drop: 3 denied, drop, then a full 8 denied before forced write
        set_dbg(1, 1, 4'hF, 32'h30, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("drop_pre_ready", 32'(dbg_ready), 0);
            chk("drop_pre_write", 32'(mem_write), 0);
            tick();
        end
        dbg_valid = 1'b0; #2;
        chk("drop_gap_write", 32'(mem_write), 0);
        tick();
        dbg_valid = 1'b1;
        n = 0;
        #2;
        while (!dbg_ready && n < 20) begin
            chk("drop_denied_write", 32'(mem_write), 0);
            tick(); #2;
            n++;
        end
        chk("drop_denied_count", 32'(n), 8);
        chk("drop_forced_write", 32'(mem_write), 1);
        tick();
        set_dbg(0, 0, 4'hF, 0, 0);
        set_cpu(1, 0, 4'hF, 32'h30, 0); #2;
        chk("drop_readback", cpu_rdata, 32'h12345678);
        tick();

        // Reset mid-operation with a partly-run counter and both stores pending
        set_cpu(1, 0, 4'hF, 32'h10, 0);
        set_dbg(1, 0, 4'hF, 32'h10, 0);
        tick(); tick(); tick();
        set_cpu(1, 1, 4'hF, 32'h50, 32'hAAAAAAAA);
        set_dbg(1, 1, 4'hF, 32'h54, 32'hBBBBBBBB);
        rst = 1'b1; #2;
        chk("midrst_write", 32'(mem_write), 0);
        chk("midrst_ready", 32'(dbg_ready), 0);
        chk("midrst_stall", 32'(cpu_stall), 0);
        tick(); #2;
        chk("midrst_rvalid", 32'(dbg_rvalid), 0);
        chk("midrst_rdata", dbg_rdata, 0);
        rst = 1'b0;
        set_cpu(1, 0, 4'hF, 32'h50, 0);
        set_dbg(1, 0, 4'hF, 32'h54, 0);
        #2;
        chk("midrst_mem50", cpu_rdata, 0);
        n = 0;
        while (!dbg_ready && n < 20) begin
            tick(); #2;
            n++;
        end
        chk("midrst_cnt_cleared", 32'(n), 8);
        tick();
        set_dbg(0, 0, 4'hF, 0, 0); #2;
        chk("midrst_mem54", dbg_rdata, 0);
        tick();

        // Alternating CPU SH / debug LW at 0x40 under contention
        set_dbg(1, 0, 4'hF, 32'h40, 0);
        for (int k = 1; k <= STARVE_LIMIT + 1; k++) begin
            set_cpu(1, 1, 4'b0011, 32'h40, 32'hFFFF0000 | 32'(16'h1000 + k));
            #2;
            if (k <= STARVE_LIMIT) chk("alt_cpu_store", 32'(mem_write & ~cpu_stall), 1);
            else                   chk("alt_dbg_forced", 32'(dbg_ready & cpu_stall), 1);
            tick();
        end
        set_dbg(0, 0, 4'hF, 0, 0); #2;
        chk("alt_dbg_rdata", dbg_rdata, 32'h00001008);
        chk("alt_stalled_store", 32'(mem_write & ~cpu_stall), 1);
        tick();
        set_cpu(0, 0, 4'hF, 0, 0);
        set_dbg(1, 0, 4'hF, 32'h40, 0); #2;
        chk("alt_dbg_alone_ready", 32'(dbg_ready), 1);
        tick();
        set_dbg(0, 0, 4'hF, 0, 0); #2;
        chk("alt_final_rdata", dbg_rdata, 32'h00001009);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
